dual_request_buffer: RTL and testbench
======================================

Name: dual_request_buffer

Overview:
- Downstream stage of the two-channel request producer.
- Consumes channels 1 and 2 (address/id/valid), buffers each in its own FIFO, and back-pressures each channel with a stall.
- Applies per-channel flush-by-ID cancellation to buffered and in-flight requests.
- Merges surviving requests round-robin onto one registered output port with a ready handshake toward the memory side.

Parameters:
- DEPTH, 4, entries per channel FIFO; power of two, at least 2.
- ADDR_W, `ADDRESS_WIDTH, request address width.
- ID_W, `ID_WIDTH (8), request ID width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid_1  in  1  channel 1 request valid
- in_address_1  in  ADDR_W  channel 1 address
- in_id_1  in  ID_W  channel 1 ID
- stall_1  out  1  channel 1 back-pressure
- flush_1  in  1  channel 1 flush strobe
- flush_id_1  in  ID_W  channel 1 ID to cancel
- in_valid_2, in_address_2, in_id_2, stall_2, flush_2, flush_id_2: same as channel 1, for channel 2
- out_valid  out  1  merged request valid
- out_address  out  ADDR_W  merged address
- out_id  out  ID_W  merged ID
- out_src  out  1  source channel (0 = ch1, 1 = ch2)
- out_ready  in  1  downstream accepts

Behaviour:
- Reset: asynchronous. FIFOs empty, all valid bits 0, stall_1/2 = 0, out_valid = 0, out_address/out_id/out_src = 0, round-robin pointer = ch1 preferred. Reset asserted mid-operation discards all contents, including a held output.
- Input acceptance: channel N accepts at a posedge when in_valid_N && !stall_N.
- Stall: stall_N = (count_N == DEPTH), combinational from count only.
  - No same-cycle pop pass-through: a full FIFO stalls even in a cycle where it pops.
  - A stalled producer holds its outputs, so no request is lost or duplicated.
- FIFO entry fields: {valid, address, id}. count_N includes cancelled entries until they are popped.
- Flush (flush_N high at a posedge), all cases on channel N only:
  - Every buffered entry of FIFO N with id == flush_id_N has its valid bit cleared.
  - A request being accepted on channel N in the same cycle with a matching id is not enqueued (count unchanged).
  - If the output register holds a channel-N request with a matching id and out_ready = 0, out_valid clears at that edge.
  - If out_ready = 1 in that same cycle, the transfer completes normally.
  - Flush never affects the other channel.
- Head skip: a FIFO whose head entry is cancelled pops that entry in the current cycle, does not request arbitration, and does not consume a grant.
- Load condition: the output register loads when (!out_valid || out_ready) and at least one channel has a valid head.
- Arbitration:
  - With one eligible channel, that channel is granted.
  - With both eligible, grant goes to the channel opposite the last grant, then the pointer updates.
  - The granted head is popped and loaded into the output register.
- Output hold: while out_valid && !out_ready, out_address/out_id/out_src are held stable.
- Latency: a request accepted at edge k is presented on out_valid after edge k+1, provided the output register is free and the request wins arbitration.
- Throughput: one request per cycle total across both channels.
- Ordering: per-channel order is preserved; no reordering within a channel.
- Pointers: read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH.

Decomposition:
- Shared package / defines.vh: ADDRESS_WIDTH, ID_WIDTH, and new constants SRC_CH1 = 0 and SRC_CH2 = 1.
- One sub-module, flush_fifo: a DEPTH-entry FIFO with CAM-style id-match invalidation, cancelled-head auto-pop, and count/full/head_valid outputs. Instantiated twice.
- The top level holds the round-robin arbiter and the output register.

Test Plan:
- Basic path: reset, then ch1 sends addr 0x4, id 0x11 with out_ready = 1 → out_valid high after the following edge with out_address 0x4, out_id 0x11, out_src 0; stall_1 stays 0.
- Round-robin: both channels stream continuously with out_ready = 1 → out_src alternates 0,1,0,1, and each channel's IDs appear in increasing order.
- Back-pressure: out_ready = 0 → each channel accepts exactly 4 requests, then stall_1 = stall_2 = 1 and the producers hold. Raise out_ready → all 8 requests plus the held output drain with no loss or duplication, and stalls drop after the first pop.
- Buffered flush: ch1 buffers ids 0x15, 0x16, 0x17; pulse flush_1 with flush_id_1 = 0x16 → output shows 0x15 then 0x17, and 0x16 never appears. Ch2 is unaffected by a flush_2 to id 0x16.
- Flush corner cases:
  - Flush 0x18 in the same cycle ch1 presents 0x18 → not enqueued.
  - Output register holds ch2 id 0x23 with out_ready = 0; flush_2 to id 0x23 → out_valid becomes 0 next cycle.
- Mid-operation reset: assert reset with both FIFOs partially full and out_valid = 1 → immediately out_valid = 0 and stalls = 0. After release, the first output is the first post-reset request.

Source files
------------

// File: rtl/dual_request_buffer_pkg.sv
// Shared widths, channel encodings and the round-robin pick helper for the
// dual-channel request buffer.
package dual_request_buffer_pkg;

    localparam int ADDRESS_WIDTH = 32;
    localparam int ID_WIDTH      = 8;

    localparam logic SRC_CH1 = 1'b0;
    localparam logic SRC_CH2 = 1'b1;

    // With both channels eligible the grant alternates away from the last winner.
    function automatic logic rr_pick(input logic last_grant,
                                     input logic eligible_1,
                                     input logic eligible_2);
        logic pick;
        if (eligible_1 && eligible_2) begin
            pick = (last_grant == SRC_CH1) ? SRC_CH2 : SRC_CH1;
        end else if (eligible_2) begin
            pick = SRC_CH2;
        end else begin
            pick = SRC_CH1;
        end
        return pick;
    endfunction

endpackage

// File: rtl/dual_request_buffer_flush_fifo.sv
// Per-channel request FIFO with id-match cancellation of buffered entries and
// automatic popping of a cancelled head so it never reaches arbitration.
module flush_fifo
    import dual_request_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = ADDRESS_WIDTH,
    parameter int ID_W   = ID_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_valid,
    input  logic [ADDR_W-1:0]        push_address,
    input  logic [ID_W-1:0]          push_id,
    input  logic                     flush,
    input  logic [ID_W-1:0]          flush_id,
    input  logic                     pop,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     head_valid,
    output logic [ADDR_W-1:0]        head_address,
    output logic [ID_W-1:0]          head_id
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [ID_W-1:0]   id_q   [DEPTH];
    logic [ID_W-1:0]   id_d   [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic not_empty;
    logic head_flushed;
    logic do_push;
    logic do_pop;

    assign not_empty = (count_q != '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign count     = count_q;

    // A head matched by this cycle's flush is already treated as cancelled.
    assign head_flushed = flush && (id_q[rd_ptr_q] == flush_id);
    assign head_valid   = not_empty && valid_q[rd_ptr_q] && !head_flushed;
    assign head_address = addr_q[rd_ptr_q];
    assign head_id      = id_q[rd_ptr_q];

    assign do_push = push_valid && !full && !(flush && (push_id == flush_id));
    assign do_pop  = pop || (not_empty && !head_valid);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
        valid_d = valid_q;
        addr_d  = addr_q;
        id_d    = id_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (flush && (id_q[i] == flush_id)) begin
                valid_d[i] = 1'b0;
            end
        end
        if (do_push) begin
            valid_d[wr_ptr_q] = 1'b1;
            addr_d[wr_ptr_q]  = push_address;
            id_d[wr_ptr_q]    = push_id;
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // NOTE: state flops use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: payload storage is not reset; the valid bits and count decide what is live.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        id_q   <= id_d;
    end

endmodule

// File: rtl/dual_request_buffer.sv
// Two-channel request buffer: per-channel flushable FIFOs merged round-robin
// into one registered output with a ready handshake.
module dual_request_buffer
    import dual_request_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = ADDRESS_WIDTH,
    parameter int ID_W   = ID_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid_1,
    input  logic [ADDR_W-1:0] in_address_1,
    input  logic [ID_W-1:0]   in_id_1,
    output logic              stall_1,
    input  logic              flush_1,
    input  logic [ID_W-1:0]   flush_id_1,
    input  logic              in_valid_2,
    input  logic [ADDR_W-1:0] in_address_2,
    input  logic [ID_W-1:0]   in_id_2,
    output logic              stall_2,
    input  logic              flush_2,
    input  logic [ID_W-1:0]   flush_id_2,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_address,
    output logic [ID_W-1:0]   out_id,
    output logic              out_src,
    input  logic              out_ready
);

    logic [$clog2(DEPTH):0] count_1, count_2;
    logic                   head_valid_1, head_valid_2;
    logic [ADDR_W-1:0]      head_address_1, head_address_2;
    logic [ID_W-1:0]        head_id_1, head_id_2;
    logic                   pop_1, pop_2;

    logic              out_valid_q, out_valid_d;
    logic [ADDR_W-1:0] out_address_q, out_address_d;
    logic [ID_W-1:0]   out_id_q, out_id_d;
    logic              out_src_q, out_src_d;
    logic              last_grant_q, last_grant_d;

    logic grant;
    logic load;
    logic held_flushed;

    flush_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .ID_W(ID_W)) u_fifo_1 (
        .clk          (clk),
        .reset        (reset),
        .push_valid   (in_valid_1),
        .push_address (in_address_1),
        .push_id      (in_id_1),
        .flush        (flush_1),
        .flush_id     (flush_id_1),
        .pop          (pop_1),
        .full         (stall_1),
        .count        (count_1),
        .head_valid   (head_valid_1),
        .head_address (head_address_1),
        .head_id      (head_id_1)
    );

    flush_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .ID_W(ID_W)) u_fifo_2 (
        .clk          (clk),
        .reset        (reset),
        .push_valid   (in_valid_2),
        .push_address (in_address_2),
        .push_id      (in_id_2),
        .flush        (flush_2),
        .flush_id     (flush_id_2),
        .pop          (pop_2),
        .full         (stall_2),
        .count        (count_2),
        .head_valid   (head_valid_2),
        .head_address (head_address_2),
        .head_id      (head_id_2)
    );

    assign grant = rr_pick(last_grant_q, head_valid_1, head_valid_2);
    assign load  = (!out_valid_q || out_ready) && (head_valid_1 || head_valid_2);
    assign pop_1 = load && (grant == SRC_CH1);
    assign pop_2 = load && (grant == SRC_CH2);

    // A held request is cancelled only by a flush from its own channel.
    assign held_flushed = out_valid_q && !out_ready &&
        (((out_src_q == SRC_CH1) && flush_1 && (out_id_q == flush_id_1)) ||
         ((out_src_q == SRC_CH2) && flush_2 && (out_id_q == flush_id_2)));

    always_comb begin
        out_valid_d   = out_valid_q;
        out_address_d = out_address_q;
        out_id_d      = out_id_q;
        out_src_d     = out_src_q;
        last_grant_d  = last_grant_q;
        if (load) begin
            out_valid_d   = 1'b1;
            out_address_d = (grant == SRC_CH2) ? head_address_2 : head_address_1;
            out_id_d      = (grant == SRC_CH2) ? head_id_2 : head_id_1;
            out_src_d     = grant;
            last_grant_d  = grant;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else if (held_flushed) begin
            out_valid_d = 1'b0;
        end
    end

    // Last grant resets to ch2 so the first contested pick goes to ch1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q   <= 1'b0;
            out_address_q <= '0;
            out_id_q      <= '0;
            out_src_q     <= SRC_CH1;
            last_grant_q  <= SRC_CH2;
        end else begin
            out_valid_q   <= out_valid_d;
            out_address_q <= out_address_d;
            out_id_q      <= out_id_d;
            out_src_q     <= out_src_d;
            last_grant_q  <= last_grant_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_address = out_address_q;
    assign out_id      = out_id_q;
    assign out_src     = out_src_q;

    count_in_range_a : assert property (@(posedge clk) disable iff (reset)
        (count_1 <= ($clog2(DEPTH)+1)'(DEPTH)) && (count_2 <= ($clog2(DEPTH)+1)'(DEPTH)));

endmodule

// File: tb/tb_dual_request_buffer.sv
// Scoreboard bench for dual_request_buffer: directed stimulus pushes expected
// outputs, a negedge monitor pops and compares every accepted transfer.
module tb_dual_request_buffer;
    import dual_request_buffer_pkg::*;

    localparam int AW = ADDRESS_WIDTH;
    localparam int IW = ID_WIDTH;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid_1, in_valid_2;
    logic [AW-1:0] in_address_1, in_address_2;
    logic [IW-1:0] in_id_1, in_id_2;
    logic          stall_1, stall_2;
    logic          flush_1, flush_2;
    logic [IW-1:0] flush_id_1, flush_id_2;
    logic          out_valid;
    logic [AW-1:0] out_address;
    logic [IW-1:0] out_id;
    logic          out_src;
    logic          out_ready;

    typedef struct packed {
        logic          src;
        logic [AW-1:0] addr;
        logic [IW-1:0] id;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    dual_request_buffer #(.DEPTH(4), .ADDR_W(AW), .ID_W(IW)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid_1   (in_valid_1),
        .in_address_1 (in_address_1),
        .in_id_1      (in_id_1),
        .stall_1      (stall_1),
        .flush_1      (flush_1),
        .flush_id_1   (flush_id_1),
        .in_valid_2   (in_valid_2),
        .in_address_2 (in_address_2),
        .in_id_2      (in_id_2),
        .stall_2      (stall_2),
        .flush_2      (flush_2),
        .flush_id_2   (flush_id_2),
        .out_valid    (out_valid),
        .out_address  (out_address),
        .out_id       (out_id),
        .out_src      (out_src),
        .out_ready    (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_out(input logic src, input logic [AW-1:0] addr, input logic [IW-1:0] id);
        exp_t e;
        e.src  = src;
        e.addr = addr;
        e.id   = id;
        exp_q.push_back(e);
    endtask

    // Monitor: a transfer happens at the next posedge whenever valid && ready.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL spurious_output: got src=%0d addr=0x%0h id=0x%0h, required no output",
                         out_src, out_address, out_id);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_src", 64'(out_src), 64'(e.src));
                check("out_address", 64'(out_address), 64'(e.addr));
                check("out_id", 64'(out_id), 64'(e.id));
            end
        end
    end

    // Producer: holds the request until a posedge where the channel is not stalled.
    task automatic send(input int ch, input logic [AW-1:0] a, input logic [IW-1:0] id);
        int   waited = 0;
        logic st;
        if (ch == 1) begin
            in_valid_1 = 1'b1; in_address_1 = a; in_id_1 = id;
        end else begin
            in_valid_2 = 1'b1; in_address_2 = a; in_id_2 = id;
        end
        forever begin
            @(negedge clk);
            st = (ch == 1) ? stall_1 : stall_2;
            @(posedge clk);
            #1;
            if (!st) break;
            waited++;
            if (waited > 100) begin
                n_tests++;
                n_fail++;
                $display("FAIL send_timeout: ch%0d id 0x%0h still stalled after %0d cycles, required acceptance",
                         ch, id, waited);
                break;
            end
        end
        if (ch == 1) in_valid_1 = 1'b0;
        else         in_valid_2 = 1'b0;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        in_valid_1 = 1'b0; in_valid_2 = 1'b0;
        flush_1    = 1'b0; flush_2    = 1'b0;
        out_ready  = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        check({name, "_remaining"}, 64'(exp_q.size()), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        check({name, "_idle_valid"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        in_valid_1 = 1'b0; in_address_1 = '0; in_id_1 = '0;
        in_valid_2 = 1'b0; in_address_2 = '0; in_id_2 = '0;
        flush_1 = 1'b0; flush_id_1 = '0;
        flush_2 = 1'b0; flush_id_2 = '0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_stall_1", 64'(stall_1), 64'd0);
        check("reset_stall_2", 64'(stall_2), 64'd0);
        check("reset_out_address", 64'(out_address), 64'd0);
        check("reset_out_id", 64'(out_id), 64'd0);
        check("reset_out_src", 64'(out_src), 64'd0);

        // Basic path
        do_reset();
        out_ready = 1'b1;
        expect_out(SRC_CH1, AW'(32'h4), 8'h11);
        send(1, AW'(32'h4), 8'h11);
        check("basic_not_yet_valid", 64'(out_valid), 64'd0);
        check("basic_stall_1", 64'(stall_1), 64'd0);
        @(posedge clk);
        #1;
        check("basic_valid", 64'(out_valid), 64'd1);
        check("basic_address", 64'(out_address), 64'h4);
        drain("basic");

        // Round-robin streaming
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            expect_out(SRC_CH1, AW'(32'h300 + i), IW'(32'h30 + i));
            expect_out(SRC_CH2, AW'(32'h400 + i), IW'(32'h40 + i));
        end
        fork
            for (int i = 1; i <= 6; i++) send(1, AW'(32'h300 + i), IW'(32'h30 + i));
            for (int j = 1; j <= 6; j++) send(2, AW'(32'h400 + j), IW'(32'h40 + j));
        join
        drain("rr");

        // Back-pressure: a1 held in the output register, 4 buffered per channel
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            expect_out(SRC_CH1, AW'(32'h500 + i), IW'(32'h50 + i));
            expect_out(SRC_CH2, AW'(32'h600 + i), IW'(32'h60 + i));
        end
        fork
            for (int i = 1; i <= 5; i++) send(1, AW'(32'h500 + i), IW'(32'h50 + i));
            for (int j = 1; j <= 5; j++) send(2, AW'(32'h600 + j), IW'(32'h60 + j));
            begin
                repeat (10) @(posedge clk);
                #1;
                check("bp_stall_1_full", 64'(stall_1), 64'd1);
                check("bp_stall_2_full", 64'(stall_2), 64'd1);
                check("bp_held_id", 64'(out_id), 64'h51);
                check("bp_held_valid", 64'(out_valid), 64'd1);
                out_ready = 1'b1;
                @(posedge clk);
                #1;
                check("bp_stall_2_drop", 64'(stall_2), 64'd0);
                check("bp_stall_1_still", 64'(stall_1), 64'd1);
            end
        join
        drain("bp");

        // Buffered flush on ch1; ch2 entry with the same id survives
        do_reset();
        expect_out(SRC_CH1, AW'(32'h114), 8'h14);
        expect_out(SRC_CH2, AW'(32'h216), 8'h16);
        expect_out(SRC_CH1, AW'(32'h115), 8'h15);
        expect_out(SRC_CH1, AW'(32'h117), 8'h17);
        fork
            begin
                send(1, AW'(32'h114), 8'h14);
                send(1, AW'(32'h115), 8'h15);
                send(1, AW'(32'h116), 8'h16);
                send(1, AW'(32'h117), 8'h17);
            end
            send(2, AW'(32'h216), 8'h16);
        join
        flush_1 = 1'b1; flush_id_1 = 8'h16;
        @(posedge clk);
        #1;
        flush_1 = 1'b0;
        check("bflush_held_kept", 64'(out_id), 64'h14);
        drain("bflush");

        // Flush of a request being accepted in the same cycle
        do_reset();
        out_ready = 1'b1;
        flush_1 = 1'b1; flush_id_1 = 8'h18;
        send(1, AW'(32'h118), 8'h18);
        flush_1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("inflight_flush_no_output", 64'(out_valid), 64'd0);
        end
        expect_out(SRC_CH1, AW'(32'h119), 8'h19);
        send(1, AW'(32'h119), 8'h19);
        drain("inflight");

        // Flush of the held output register
        do_reset();
        send(2, AW'(32'h223), 8'h23);
        @(posedge clk);
        #1;
        check("held_valid", 64'(out_valid), 64'd1);
        check("held_id", 64'(out_id), 64'h23);
        check("held_src", 64'(out_src), 64'd1);
        flush_1 = 1'b1; flush_id_1 = 8'h23;
        @(posedge clk);
        #1;
        flush_1 = 1'b0;
        check("held_other_channel_flush", 64'(out_valid), 64'd1);
        flush_2 = 1'b1; flush_id_2 = 8'h23;
        @(posedge clk);
        #1;
        flush_2 = 1'b0;
        check("held_flush_clears", 64'(out_valid), 64'd0);
        send(2, AW'(32'h224), 8'h24);
        @(posedge clk);
        #1;
        check("held2_id", 64'(out_id), 64'h24);
        expect_out(SRC_CH2, AW'(32'h224), 8'h24);
        flush_2 = 1'b1; flush_id_2 = 8'h24;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush_2 = 1'b0;
        drain("held");

        // Mid-operation reset
        do_reset();
        fork
            for (int i = 1; i <= 3; i++) send(1, AW'(32'h170 + i), IW'(32'h70 + i));
            for (int j = 1; j <= 2; j++) send(2, AW'(32'h280 + j), IW'(32'h80 + j));
        join
        check("mid_pre_valid", 64'(out_valid), 64'd1);
        #3;
        reset = 1'b1;
        #1;
        check("mid_reset_valid", 64'(out_valid), 64'd0);
        check("mid_reset_stall_1", 64'(stall_1), 64'd0);
        check("mid_reset_stall_2", 64'(stall_2), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        expect_out(SRC_CH2, AW'(32'h291), 8'h91);
        send(2, AW'(32'h291), 8'h91);
        drain("mid");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
